// File: rtl/vector_rx_assembler.sv
// Byte-to-vector deserializer: turns UART command/data bytes into committed 10-bit element vectors A/B.
// Latency: command_ready 1 cycle after the last required byte; data_a/data_b/write_done 1 cycle after begin_write.
// Backpressure: none on rx (bytes arriving in WAIT_BEGIN/WAIT_OP are dropped); control unit paces via begin_write/op_done.
//
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   rx_ready, rx_data     : received byte strobe and value
//   begin_write, op_done  : control-unit handshakes (already synchronized)
//   command_ready/command : pending command byte (level, held until done)
//   data_a, data_b        : committed vectors, NUM_ELEMENTOS x 10 bits
//   write_done            : 1-cycle commit pulse
//   frame_error           : 1-cycle pulse when a write frame times out
//   busy                  : high whenever not in IDLE
//
// Optional feature: define RX_TIMEOUT_EN to build the inter-byte timeout
// counter for write frames; otherwise frame_error is tied low.
module vector_rx_assembler #(
  parameter int NUM_ELEMENTOS  = 8,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rx_ready,
  input  logic [7:0]                     rx_data,
  input  logic                           begin_write,
  input  logic                           op_done,
  output logic                           command_ready,
  output logic [7:0]                     command,
  output logic [NUM_ELEMENTOS-1:0][9:0]  data_a,
  output logic [NUM_ELEMENTOS-1:0][9:0]  data_b,
  output logic                           write_done,
  output logic                           frame_error,
  output logic                           busy
);

  localparam logic [7:0] CMD_WRITE_A = 8'h01;
  localparam logic [7:0] CMD_WRITE_B = 8'h02;
  localparam int         IW          = (NUM_ELEMENTOS > 1) ? $clog2(NUM_ELEMENTOS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEMENTOS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_DATA,
    ST_WAIT_BEGIN,
    ST_WAIT_OP
  } state_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            phase_hi_q, phase_hi_d;
  logic [NUM_ELEMENTOS-1:0][9:0]   staging_q, staging_d;
  logic [NUM_ELEMENTOS-1:0][9:0]   data_a_q, data_a_d;
  logic [NUM_ELEMENTOS-1:0][9:0]   data_b_q, data_b_d;
  logic [7:0]                      command_q, command_d;
  logic                            command_ready_q, command_ready_d;
  logic                            write_done_q, write_done_d;
  logic                            tmo_expire;

`ifdef RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          frame_error_q, frame_error_d;

  // Expiry only when no byte shows up in that same cycle: a late byte wins.
  always_comb begin
    tmo_expire    = (state_q == ST_RX_DATA) && !rx_ready &&
                    (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    frame_error_d = tmo_expire;
    tmo_cnt_d     = tmo_cnt_q + CW'(1);
    // Counter idles at zero outside RX_DATA and reloads on each accepted byte.
    if (state_q != ST_RX_DATA || rx_ready || tmo_expire) begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      frame_error_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign frame_error = frame_error_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_expire  = 1'b0;
  assign frame_error = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    phase_hi_d      = phase_hi_q;
    staging_d       = staging_q;
    data_a_d        = data_a_q;
    data_b_d        = data_b_q;
    command_d       = command_q;
    command_ready_d = command_ready_q;
    write_done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_ready) begin
          command_d = rx_data;
          if (rx_data == CMD_WRITE_A || rx_data == CMD_WRITE_B) begin
            state_d    = ST_RX_DATA;
            idx_d      = '0;
            phase_hi_d = 1'b0;
          end else begin
            command_ready_d = 1'b1;
            state_d         = ST_WAIT_OP;
          end
        end
      end

      ST_RX_DATA: begin
        if (rx_ready) begin
          if (!phase_hi_q) begin
            staging_d[idx_q][7:0] = rx_data;
            phase_hi_d            = 1'b1;
          end else begin
            // Only the two LSBs of the high byte carry element bits.
            staging_d[idx_q][9:8] = rx_data[1:0];
            phase_hi_d            = 1'b0;
            if (idx_q == LAST_IDX) begin
              command_ready_d = 1'b1;
              state_d         = ST_WAIT_BEGIN;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end else if (tmo_expire) begin
          // Partial frame abandoned; staging is never visible so no cleanup needed.
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_BEGIN: begin
        if (begin_write) begin
          if (command_q == CMD_WRITE_A) begin
            data_a_d = staging_q;
          end else begin
            data_b_d = staging_q;
          end
          write_done_d    = 1'b1;
          command_ready_d = 1'b0;
          state_d         = ST_IDLE;
        end
      end

      ST_WAIT_OP: begin
        if (op_done) begin
          command_ready_d = 1'b0;
          state_d         = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      phase_hi_q      <= 1'b0;
      staging_q       <= '0;
      data_a_q        <= '0;
      data_b_q        <= '0;
      command_q       <= 8'h00;
      command_ready_q <= 1'b0;
      write_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      phase_hi_q      <= phase_hi_d;
      staging_q       <= staging_d;
      data_a_q        <= data_a_d;
      data_b_q        <= data_b_d;
      command_q       <= command_d;
      command_ready_q <= command_ready_d;
      write_done_q    <= write_done_d;
    end
  end

  assign command_ready = command_ready_q;
  assign command       = command_q;
  assign data_a        = data_a_q;
  assign data_b        = data_b_q;
  assign write_done    = write_done_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/vector_rx_assembler.md
# vector_rx_assembler

Byte-to-vector deserializer in the input clock domain. Sits between `uart_basic` (rx side) and the processing pipeline. Parses each UART command byte. For write commands, it assembles `NUM_ELEMENTOS` 10-bit elements from byte pairs into a staging buffer, then commits them to the A or B vector when the control unit grants the write. For operation commands, it raises `command_ready` and holds it until the control unit reports `op_done`.

## Interface
Parameters:
- `NUM_ELEMENTOS`, 8: elements per vector (≥2).
- `TIMEOUT_CYCLES`, 10_000_000: idle cycles allowed between bytes of one write frame.

Ports:
- `clk`  in  1  input-domain clock; one clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_ready`  in  1  one-cycle strobe: `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `begin_write`  in  1  level from control unit (already synchronized): commit staging buffer.
- `op_done`  in  1  one-cycle pulse (already synchronized): operation finished.
- `command_ready`  out  1  level: `command` is valid and pending.
- `command`  out  8  last accepted command byte.
- `data_a`  out  `[NUM_ELEMENTOS]` × 10  committed vector A.
- `data_b`  out  `[NUM_ELEMENTOS]` × 10  committed vector B.
- `write_done`  out  1  one-cycle pulse: commit performed.
- `frame_error`  out  1  one-cycle pulse: write frame aborted by timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Commands:
  - `0x01` is WRITE_A and `0x02` is WRITE_B.
  - Every other value is an operation command and is passed through unchanged.
- Write frame: command byte, then 2·`NUM_ELEMENTOS` bytes in element order 0..N-1.
  - Each element is sent as low byte then high byte.
  - Element value = {high[1:0], low[7:0]}; high[7:2] are discarded.
- States:
  - IDLE: on `rx_ready`, latch `command`. WRITE_A/B → RX_DATA with element index 0 and phase LOW. Otherwise → set `command_ready` → WAIT_OP.
  - RX_DATA: each `rx_ready` writes the byte into staging[index] at the current phase. Phase toggles; index increments after the HIGH byte. After the HIGH byte of element N-1 → set `command_ready` → WAIT_BEGIN.
  - WAIT_BEGIN: when `begin_write`=1, copy staging into `data_a` (WRITE_A) or `data_b` (WRITE_B). Same edge: pulse `write_done`, clear `command_ready` → IDLE.
  - WAIT_OP: when `op_done`=1, clear `command_ready` → IDLE.
- Bytes arriving in WAIT_BEGIN or WAIT_OP are dropped without side effects.
- `op_done` outside WAIT_OP and `begin_write` outside WAIT_BEGIN are ignored.
- The non-targeted vector is never modified. Staging contents are not visible on the outputs before commit.
- Reset:
  - All outputs go to 0, including `data_a` and `data_b` (all elements 0).
  - State → IDLE; index, phase and timeout counter cleared.
  - This applies at any point, including mid-frame and mid-handshake.

## Timing
- `command_ready` rises on the clock edge after the `rx_ready` cycle of the last required byte.
  - Operation command: 1-cycle latency from its byte.
  - Write command: 1 cycle after the final data byte.
- `command` is stable from `command_ready` rise until the next command byte is accepted in IDLE.
- Commit latency: `data_*` update and `write_done` go high on the edge following the first cycle with `begin_write`=1. `write_done` is exactly 1 cycle wide.
- `command_ready` falls on the edge following `op_done`, or together with `write_done`.
- A new command byte is accepted the cycle after returning to IDLE.
- `begin_write` held high after the commit has no further effect.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - In RX_DATA, a counter counts cycles without `rx_ready` and reloads on every accepted byte.
  - On reaching `TIMEOUT_CYCLES`: pulse `frame_error` for 1 cycle, discard the partial frame → IDLE. `data_a` and `data_b` are unchanged.
  - If `rx_ready` arrives in the expiry cycle, the byte wins and no error is raised.
- `RX_TIMEOUT_EN` undefined:
  - No counter is built; RX_DATA waits indefinitely.
  - `frame_error` is tied to 0.

## Test plan
- Operation command: byte `0x04`, `op_done` pulse 20 cycles later.
  - Required: `command`=0x04 and `command_ready`=1 one cycle after the byte.
  - Required: `command_ready`=0 one cycle after `op_done`; `busy` low again.
- WRITE_A with N=8: `0x01` then pairs (i, 0xFF) for i=0..7, `begin_write` held low 50 cycles then raised.
  - Required: `data_a` stays 0 while `begin_write` is low.
  - Required: one cycle after the rise, `data_a[i]`=0x300+i, `write_done` pulses once, `data_b` stays 0.
- Dropped bytes: send `0x05`, then bytes `0x01` and `0x22` while in WAIT_OP, then `op_done`.
  - Required: `command` remains 0x05 throughout; state returns to IDLE with no frame started.
- Timeout (`RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100): `0x02` plus 5 data bytes, then silence.
  - Required: `frame_error` pulses exactly 100 cycles after the 5th byte; `data_b` unchanged.
  - Required: a following `0x04` byte is accepted as an operation command.
- Timeout boundary: a byte arriving in the expiry cycle produces no `frame_error` and the frame continues.
- Reset mid-frame: `reset` asserted after 7 data bytes of WRITE_B.
  - Required: all outputs 0 and state IDLE on the next edge.
  - Required: a full fresh WRITE_B frame then commits correct values.
